// File: rtl/instr_decode_queue.sv
// Buffered instruction field decoder: a DEPTH-entry show-ahead FIFO of packed instruction
// words whose head entry is sliced into decode fields for the TPU controller.
module instr_decode_queue #(
    parameter int unsigned  OP_W    = 10,
    parameter int unsigned  ADDR_W  = 13,
    parameter int unsigned  DEPTH   = 4,
    parameter int unsigned  CNT_W   = 16,
    localparam int unsigned INSTR_W = 2 + OP_W + 4 * ADDR_W,
    localparam int unsigned LEN_W   = OP_W + ADDR_W,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEN_W-1:0]   len_decode,
    output logic [OP_W-1:0]    opcode_decode,
    output logic [ADDR_W-1:0]  addr_const_decode,
    output logic [ADDR_W-1:0]  addr_out_decode,
    output logic [ADDR_W-1:0]  addr_b_decode,
    output logic [ADDR_W-1:0]  addr_a_decode,
    output logic [1:0]         mode_decode,
    output logic               illegal,
    output logic [CW-1:0]      count,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               push, pop;
    logic [INSTR_W-1:0] head;

    // in_ready depends only on occupancy: no pass-through when full.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        retired_d = retired_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            retired_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                retired_d = retired_q + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            retired_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            retired_q <= retired_d;
        end
    end

    // Storage needs no reset; reads are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    always_comb begin
        len_decode        = head[LEN_W-1:0];
        opcode_decode     = head[OP_W-1:0];
        addr_const_decode = head[OP_W +: ADDR_W];
        addr_out_decode   = head[OP_W + ADDR_W +: ADDR_W];
        addr_b_decode     = head[OP_W + 2 * ADDR_W +: ADDR_W];
        addr_a_decode     = head[OP_W + 3 * ADDR_W +: ADDR_W];
        mode_decode       = head[INSTR_W-1 -: 2];
        illegal           = (head[INSTR_W-1 -: 2] == 2'b11);
        count             = count_q;
        retired           = retired_q;
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instr_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_instr = 64'd0;

    logic        in_ready, out_valid, illegal;
    logic [22:0] len_decode;
    logic [9:0]  opcode_decode;
    logic [12:0] addr_const_decode, addr_out_decode, addr_b_decode, addr_a_decode;
    logic [1:0]  mode_decode;
    logic [2:0]  count;
    logic [15:0] retired;

    // Second instance with a narrow counter, driven identically, for wrap checks.
    logic        in_ready2, out_valid2, illegal2;
    logic [22:0] len2;
    logic [9:0]  op2;
    logic [12:0] ac2, ao2, ab2, aa2;
    logic [1:0]  mode2;
    logic [2:0]  count2;
    logic [3:0]  retired2;

    instr_decode_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .len_decode(len_decode), .opcode_decode(opcode_decode),
        .addr_const_decode(addr_const_decode), .addr_out_decode(addr_out_decode),
        .addr_b_decode(addr_b_decode), .addr_a_decode(addr_a_decode),
        .mode_decode(mode_decode), .illegal(illegal), .count(count), .retired(retired)
    );

    instr_decode_queue #(.CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .out_valid(out_valid2), .out_ready(out_ready),
        .len_decode(len2), .opcode_decode(op2),
        .addr_const_decode(ac2), .addr_out_decode(ao2),
        .addr_b_decode(ab2), .addr_a_decode(aa2),
        .mode_decode(mode2), .illegal(illegal2), .count(count2), .retired(retired2)
    );

    always #5 clk = ~clk;

    logic [63:0] q[$];
    int unsigned ret_model = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] h;
    logic [63:0] w [5];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Reference model advances on each rising edge with the inputs held during the cycle.
    task automatic cycle();
        bit push, pop;
        push = in_valid && (q.size() < 4) && !flush;
        pop  = out_ready && (q.size() != 0) && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
            ret_model = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                ret_model++;
            end
            if (push) q.push_back(in_instr);
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; cycle(); flush = 1'b0;
    endtask

    always @(negedge clk) begin
        h = (q.size() != 0) ? q[0] : 64'd0;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 4});
        chk("count", {61'd0, count}, 64'(q.size()));
        chk("retired", {48'd0, retired}, 64'(ret_model % 65536));
        chk("retired_w4", {60'd0, retired2}, 64'(ret_model % 16));
        chk("len", {41'd0, len_decode}, h & 64'h7F_FFFF);
        chk("opcode", {54'd0, opcode_decode}, h & 64'h3FF);
        chk("addr_const", {51'd0, addr_const_decode}, (h >> 10) & 64'h1FFF);
        chk("addr_out", {51'd0, addr_out_decode}, (h >> 23) & 64'h1FFF);
        chk("addr_b", {51'd0, addr_b_decode}, (h >> 36) & 64'h1FFF);
        chk("addr_a", {51'd0, addr_a_decode}, (h >> 49) & 64'h1FFF);
        chk("mode", {62'd0, mode_decode}, h >> 62);
        chk("illegal", {63'd0, illegal}, {63'd0, (h >> 62) == 64'd3});
    end

    initial begin
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word
        in_valid = 1'b1; in_instr = 64'h400A_0060_0380_0403; cycle(); idle();
        chk("sw_valid", {63'd0, out_valid}, 64'd1);
        chk("sw_opcode", {54'd0, opcode_decode}, 64'h003);
        chk("sw_const", {51'd0, addr_const_decode}, 64'h0001);
        chk("sw_out", {51'd0, addr_out_decode}, 64'h0007);
        chk("sw_b", {51'd0, addr_b_decode}, 64'h0006);
        chk("sw_a", {51'd0, addr_a_decode}, 64'h0005);
        chk("sw_mode", {62'd0, mode_decode}, 64'd1);
        chk("sw_len", {41'd0, len_decode}, 64'h000403);
        chk("sw_illegal", {63'd0, illegal}, 64'd0);
        chk("sw_count", {61'd0, count}, 64'd1);
        out_ready = 1'b1; cycle(); idle();
        chk("sw_pop_valid", {63'd0, out_valid}, 64'd0);
        chk("sw_pop_opcode", {54'd0, opcode_decode}, 64'd0);
        chk("sw_retired", {48'd0, retired}, 64'd1);

        // Fill to full, hold a fifth word, drain five
        do_flush();
        for (int i = 0; i < 5; i++) w[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = w[i]; cycle();
        end
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        in_instr = w[4]; cycle();
        chk("full_hold_count", {61'd0, count}, 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_order", {41'd0, len_decode}, w[i] & 64'h7F_FFFF);
            cycle();
            if (i == 1) in_valid = 1'b0;
        end
        idle();
        chk("drain_empty", {63'd0, out_valid}, 64'd0);
        chk("drain_retired", {48'd0, retired}, 64'd5);

        // Streaming 20 words
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_instr = {$urandom, $urandom}; cycle();
            chk("stream_count", {61'd0, count}, 64'd1);
        end
        in_valid = 1'b0; cycle(); idle();
        chk("stream_retired", {48'd0, retired}, 64'd25);

        // Reserved mode
        do_flush();
        in_valid = 1'b1; in_instr = 64'hC000_0000_0000_0000; cycle(); idle();
        chk("rsv_illegal", {63'd0, illegal}, 64'd1);
        chk("rsv_mode", {62'd0, mode_decode}, 64'd3);
        out_ready = 1'b1; cycle(); idle();
        chk("rsv_retired", {48'd0, retired}, 64'd1);
        chk("rsv_illegal_after", {63'd0, illegal}, 64'd0);

        // Flush with simultaneous push/pop at count=3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = {$urandom, $urandom}; cycle();
        end
        chk("fl_count3", {61'd0, count}, 64'd3);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 64'hDEAD_BEEF_0000_0001;
        cycle(); idle();
        chk("fl_count", {61'd0, count}, 64'd0);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_retired", {48'd0, retired}, 64'd0);
        cycle();
        chk("fl_dropped", {63'd0, out_valid}, 64'd0);

        // Async reset mid-cycle with count=2
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = {$urandom, $urandom} | 64'h1; cycle();
        end
        idle();
        #2 rst_n = 1'b0;
        q.delete(); ret_model = 0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_count", {61'd0, count}, 64'd0);
        chk("ar_opcode", {54'd0, opcode_decode}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        in_valid = 1'b1; in_instr = 64'h1; cycle(); idle();
        chk("ar_push_opcode", {54'd0, opcode_decode}, 64'h001);
        chk("ar_push_count", {61'd0, count}, 64'd1);

        // Counter wrap on the 4-bit instance
        do_flush();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_instr = {$urandom, $urandom}; cycle();
        end
        in_valid = 1'b0; cycle(); idle();
        chk("wrap_retired_w4", {60'd0, retired2}, 64'd1);
        chk("wrap_retired_w16", {48'd0, retired}, 64'd17);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = {$urandom, $urandom};
            cycle();
        end
        idle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
